// File: rtl/ongoru_guncelleme_hakemi_pkg.sv
// Shared types and constants for the predictor update arbiter.
//   durum_e              : arbiter state (Bosta / Bekle / Zorla)
//   guncelleme_girdisi_t : one queued resolution {ps, yanlis, atladi}
//   PS_GENISLIK          : program counter width
package ongoru_guncelleme_hakemi_pkg;

  localparam int unsigned PS_GENISLIK = 32;

  typedef enum logic [1:0] {
    Bosta = 2'd0,
    Bekle = 2'd1,
    Zorla = 2'd2
  } durum_e;

  typedef struct packed {
    logic [PS_GENISLIK-1:0] ps;
    logic                   yanlis;
    logic                   atladi;
  } guncelleme_girdisi_t;

endpackage

// File: rtl/ongoru_guncelleme_fifo.sv
// Synchronous FIFO for queued predictor updates.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   yaz_i          : push request (ignored while full)
//   yaz_veri_i     : entry to push
//   oku_i          : pop request (ignored while empty)
//   bas_o          : head entry (undefined content while empty)
//   sayi_o         : registered occupancy
//   hazir_o        : space available, from the registered count
//   bos_degil_o    : at least one entry queued
module ongoru_guncelleme_fifo
  import ongoru_guncelleme_hakemi_pkg::*;
#(
  parameter int unsigned DERINLIK = 4,
  localparam int unsigned SayiW = $clog2(DERINLIK) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                yaz_i,
  input  guncelleme_girdisi_t yaz_veri_i,
  input  logic                oku_i,
  output guncelleme_girdisi_t bas_o,
  output logic [SayiW-1:0]    sayi_o,
  output logic                hazir_o,
  output logic                bos_degil_o
);

  localparam int unsigned PtrW = $clog2(DERINLIK);

  guncelleme_girdisi_t mem_q [DERINLIK];
  logic [PtrW-1:0]     yaz_ptr_q, yaz_ptr_d;
  logic [PtrW-1:0]     oku_ptr_q, oku_ptr_d;
  logic [SayiW-1:0]    sayi_q, sayi_d;
  logic                yaz, oku;

  assign hazir_o     = (sayi_q != SayiW'(DERINLIK));
  assign bos_degil_o = (sayi_q != '0);
  assign sayi_o      = sayi_q;
  assign bas_o       = mem_q[oku_ptr_q];

  assign yaz = yaz_i & hazir_o;
  assign oku = oku_i & bos_degil_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayi_d    = sayi_q;
    if (yaz) yaz_ptr_d = yaz_ptr_q + 1'b1;
    if (oku) oku_ptr_d = oku_ptr_q + 1'b1;
    case ({yaz, oku})
      2'b10:   sayi_d = sayi_q + 1'b1;
      2'b01:   sayi_d = sayi_q - 1'b1;
      default: sayi_d = sayi_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayi_q    <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayi_q    <= sayi_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (yaz) mem_q[yaz_ptr_q] <= yaz_veri_i;
  end

endmodule

// File: rtl/ongoru_guncelleme_hakemi.sv
// Arbiter between fetch lookups and execute resolution updates on the shared
// gshare predictor port. Resolutions are queued and issued only in cycles
// without a lookup; if the head waits too long, fetch is stalled for one cycle
// and the head is forced out.
// Optional feature macro: ONGORU_SAYAC_EN adds issued-update counters.
// Ports:
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   tahmin_ps_gecerli_i, tahmin_ps_i    : fetch lookup request / PC
//   yurut_ps_gecerli_i, yurut_ps_i      : execute resolution valid / PC
//   yanlis_tahmin_i, yurut_atladi_i     : resolution mispredict / taken flags
//   yurut_hazir_o                       : queue can accept a resolution
//   getir_durdur_o                      : fetch stall (forced-update cycle)
//   ts_tahmin_gecerli_o, ts_tahmin_ps_o : lookup toward predictor
//   ts_yurut_*_o                        : update toward predictor
//   toplam_guncelleme_o                 : issued updates (ONGORU_SAYAC_EN)
//   yanlis_guncelleme_o                 : issued mispredict updates (ONGORU_SAYAC_EN)
module ongoru_guncelleme_hakemi
  import ongoru_guncelleme_hakemi_pkg::*;
#(
  parameter int unsigned FIFO_DERINLIK  = 4,
  parameter int unsigned BEKLEME_SINIRI = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tahmin_ps_gecerli_i,
  input  logic [31:0] tahmin_ps_i,
  input  logic        yurut_ps_gecerli_i,
  input  logic [31:0] yurut_ps_i,
  input  logic        yanlis_tahmin_i,
  input  logic        yurut_atladi_i,
  output logic        yurut_hazir_o,
  output logic        getir_durdur_o,
`ifdef ONGORU_SAYAC_EN
  output logic [31:0] toplam_guncelleme_o,
  output logic [31:0] yanlis_guncelleme_o,
`endif
  output logic        ts_tahmin_gecerli_o,
  output logic [31:0] ts_tahmin_ps_o,
  output logic        ts_yurut_gecerli_o,
  output logic [31:0] ts_yurut_ps_o,
  output logic        ts_yanlis_tahmin_o,
  output logic        ts_yurut_atladi_o
);

  localparam int unsigned SayiW = $clog2(FIFO_DERINLIK) + 1;
  localparam int unsigned BekW  = $clog2(BEKLEME_SINIRI);
  localparam logic [BekW-1:0] SinirM1 = BekW'(BEKLEME_SINIRI - 1);

  durum_e              durum_q, durum_d;
  logic [BekW-1:0]     bekleme_q, bekleme_d;
  guncelleme_girdisi_t yeni, bas;
  logic [SayiW-1:0]    sayi;
  logic                hazir, bos_degil;
  logic                itme, ver, engelli, zorla, son_girdi;

  assign yeni = '{ps: yurut_ps_i, yanlis: yanlis_tahmin_i, atladi: yurut_atladi_i};

  ongoru_guncelleme_fifo #(
    .DERINLIK (FIFO_DERINLIK)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .yaz_i       (itme),
    .yaz_veri_i  (yeni),
    .oku_i       (ver),
    .bas_o       (bas),
    .sayi_o      (sayi),
    .hazir_o     (hazir),
    .bos_degil_o (bos_degil)
  );

  assign zorla     = (durum_q == Zorla);
  assign itme      = yurut_ps_gecerli_i & hazir;
  assign ver       = bos_degil & (~tahmin_ps_gecerli_i | zorla);
  assign engelli   = bos_degil & ~ver;
  // Popping the last entry with nothing arriving leaves the queue empty.
  assign son_girdi = (sayi == SayiW'(1)) & ~itme;

  assign yurut_hazir_o       = hazir;
  assign getir_durdur_o      = zorla;
  assign ts_tahmin_gecerli_o = tahmin_ps_gecerli_i & ~zorla;
  assign ts_tahmin_ps_o      = tahmin_ps_i;
  assign ts_yurut_gecerli_o  = ver;
  // Head drives the update port directly; zeroed while the queue is empty.
  assign ts_yurut_ps_o       = bos_degil ? bas.ps : '0;
  assign ts_yanlis_tahmin_o  = bos_degil & bas.yanlis;
  assign ts_yurut_atladi_o   = bos_degil & bas.atladi;

  always_comb begin
    durum_d   = durum_q;
    bekleme_d = bekleme_q;

    if (!bos_degil || ver) begin
      bekleme_d = '0;
    end else if (bekleme_q != SinirM1) begin
      bekleme_d = bekleme_q + 1'b1;
    end

    case (durum_q)
      Bosta: if (itme) durum_d = Bekle;
      Bekle: begin
        if (engelli && (bekleme_q == SinirM1)) begin
          durum_d = Zorla;
        end else if (ver && son_girdi) begin
          durum_d = Bosta;
        end
      end
      Zorla:   durum_d = son_girdi ? Bosta : Bekle;
      default: durum_d = Bosta;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q   <= Bosta;
      bekleme_q <= '0;
    end else begin
      durum_q   <= durum_d;
      bekleme_q <= bekleme_d;
    end
  end

`ifdef ONGORU_SAYAC_EN
  logic [31:0] toplam_q, yanlis_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toplam_q <= '0;
      yanlis_q <= '0;
    end else if (ver) begin
      toplam_q <= toplam_q + 32'd1;
      if (bas.yanlis) yanlis_q <= yanlis_q + 32'd1;
    end
  end

  assign toplam_guncelleme_o = toplam_q;
  assign yanlis_guncelleme_o = yanlis_q;
`endif

endmodule

// File: tb/tb_ongoru_guncelleme_hakemi.sv
// Self-checking bench for ongoru_guncelleme_hakemi: a queue-based reference
// model is compared every cycle, plus directed scenarios with literal
// expectations, then a randomized run.
module tb_ongoru_guncelleme_hakemi;

  localparam int unsigned D = 4;
  localparam int unsigned L = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tahmin_ps_gecerli_i = 1'b0;
  logic [31:0] tahmin_ps_i = '0;
  logic        yurut_ps_gecerli_i = 1'b0;
  logic [31:0] yurut_ps_i = '0;
  logic        yanlis_tahmin_i = 1'b0;
  logic        yurut_atladi_i = 1'b0;
  logic        yurut_hazir_o, getir_durdur_o;
  logic        ts_tahmin_gecerli_o, ts_yurut_gecerli_o;
  logic [31:0] ts_tahmin_ps_o, ts_yurut_ps_o;
  logic        ts_yanlis_tahmin_o, ts_yurut_atladi_o;
`ifdef ONGORU_SAYAC_EN
  logic [31:0] toplam_guncelleme_o, yanlis_guncelleme_o;
`endif

  ongoru_guncelleme_hakemi #(
    .FIFO_DERINLIK  (D),
    .BEKLEME_SINIRI (L)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .tahmin_ps_gecerli_i (tahmin_ps_gecerli_i),
    .tahmin_ps_i         (tahmin_ps_i),
    .yurut_ps_gecerli_i  (yurut_ps_gecerli_i),
    .yurut_ps_i          (yurut_ps_i),
    .yanlis_tahmin_i     (yanlis_tahmin_i),
    .yurut_atladi_i      (yurut_atladi_i),
    .yurut_hazir_o       (yurut_hazir_o),
    .getir_durdur_o      (getir_durdur_o),
`ifdef ONGORU_SAYAC_EN
    .toplam_guncelleme_o (toplam_guncelleme_o),
    .yanlis_guncelleme_o (yanlis_guncelleme_o),
`endif
    .ts_tahmin_gecerli_o (ts_tahmin_gecerli_o),
    .ts_tahmin_ps_o      (ts_tahmin_ps_o),
    .ts_yurut_gecerli_o  (ts_yurut_gecerli_o),
    .ts_yurut_ps_o       (ts_yurut_ps_o),
    .ts_yanlis_tahmin_o  (ts_yanlis_tahmin_o),
    .ts_yurut_atladi_o   (ts_yurut_atladi_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a plain queue, a wait counter and a forced-cycle flag.
  typedef struct {
    logic [31:0] ps;
    bit          y;
    bit          a;
  } ent_t;

  ent_t        q[$];
  int          bekle;
  bit          zorla_m;
  int unsigned m_toplam, m_yanlis;

  int vectors = 0;
  int miscompares = 0;

  // Values observed in the last cycle and whether the model accepted a push.
  bit          kabul;
  logic        obs_hazir, obs_stall, obs_tv, obs_yv, obs_y, obs_a;
  logic [31:0] obs_ps;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic void model_sifirla();
    q.delete();
    bekle    = 0;
    zorla_m  = 0;
    m_toplam = 0;
    m_yanlis = 0;
  endfunction

  task automatic sun(input logic [31:0] ps, input bit y, input bit a);
    yurut_ps_gecerli_i = 1'b1;
    yurut_ps_i         = ps;
    yanlis_tahmin_i    = y;
    yurut_atladi_i     = a;
  endtask

  // One clock cycle: compare outputs against the model, then advance it.
  task automatic adim();
    bit bos, ver, hz, push, blk;
    #1;
    bos = (q.size() == 0);
    ver = !bos && (!tahmin_ps_gecerli_i || zorla_m);
    hz  = (q.size() != D);
    obs_hazir = yurut_hazir_o;
    obs_stall = getir_durdur_o;
    obs_tv    = ts_tahmin_gecerli_o;
    obs_yv    = ts_yurut_gecerli_o;
    obs_ps    = ts_yurut_ps_o;
    obs_y     = ts_yanlis_tahmin_o;
    obs_a     = ts_yurut_atladi_o;
    chk("hazir", yurut_hazir_o, hz);
    chk("durdur", getir_durdur_o, zorla_m);
    chk("tahmin_gecerli", ts_tahmin_gecerli_o, tahmin_ps_gecerli_i && !zorla_m);
    chk("tahmin_ps", ts_tahmin_ps_o, tahmin_ps_i);
    chk("yurut_gecerli", ts_yurut_gecerli_o, ver);
    if (ver) begin
      chk("yurut_ps", ts_yurut_ps_o, q[0].ps);
      chk("yanlis", ts_yanlis_tahmin_o, q[0].y);
      chk("atladi", ts_yurut_atladi_o, q[0].a);
    end else if (bos) begin
      chk("bos_ps", ts_yurut_ps_o, 0);
      chk("bos_bayrak", {ts_yanlis_tahmin_o, ts_yurut_atladi_o}, 0);
    end
`ifdef ONGORU_SAYAC_EN
    chk("toplam", toplam_guncelleme_o, m_toplam);
    chk("yanlis_say", yanlis_guncelleme_o, m_yanlis);
`endif
    @(posedge clk_i);
    push = yurut_ps_gecerli_i && hz;
    blk  = !bos && !ver;
    if (ver) begin
      m_toplam++;
      if (q[0].y) m_yanlis++;
      void'(q.pop_front());
    end
    if (push) q.push_back('{ps: yurut_ps_i, y: yanlis_tahmin_i, a: yurut_atladi_i});
    zorla_m = blk && (bekle == L - 1);
    if (bos || ver) bekle = 0;
    else if (bekle < L - 1) bekle++;
    kabul = push;
    #1;
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any edge.
  task automatic sifirla();
    rst_ni = 1'b0;
    #1;
    chk("rst_hazir", yurut_hazir_o, 1);
    chk("rst_durdur", getir_durdur_o, 0);
    chk("rst_yurut_gecerli", ts_yurut_gecerli_o, 0);
    chk("rst_yurut_ps", ts_yurut_ps_o, 0);
    chk("rst_tahmin_gecerli", ts_tahmin_gecerli_o, tahmin_ps_gecerli_i);
    model_sifirla();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  int          stall_idx, n_stall, n_sent, acc5, n_ver, pct;
  logic [31:0] issued[$];

  initial begin
    model_sifirla();
    #2;
    chk("ilk_hazir", yurut_hazir_o, 1);
    chk("ilk_durdur", getir_durdur_o, 0);
    chk("ilk_yurut_gecerli", ts_yurut_gecerli_o, 0);
    #10 rst_ni = 1'b1;

    // Single resolution, no lookups: issued the very next cycle.
    tahmin_ps_gecerli_i = 1'b0;
    sun(32'h100, 1'b1, 1'b1);
    adim();
    chk("t1_kabul", kabul, 1);
    yurut_ps_gecerli_i = 1'b0;
    adim();
    chk("t1_gecerli", obs_yv, 1);
    chk("t1_ps", obs_ps, 32'h100);
    chk("t1_bayrak", {obs_y, obs_a}, 2'b11);
    adim();
    chk("t1_bos", obs_yv, 0);
    chk("t1_hazir", obs_hazir, 1);

    // Lookup held: the head is forced out with a single stall cycle.
    sifirla();
    tahmin_ps_gecerli_i = 1'b1;
    sun(32'h200, 1'b0, 1'b1);
    stall_idx = -1;
    n_stall   = 0;
    for (int i = 0; i < 14; i++) begin
      tahmin_ps_i = $urandom;
      adim();
      if (kabul) yurut_ps_gecerli_i = 1'b0;
      if (obs_stall) begin
        n_stall++;
        if (stall_idx < 0) stall_idx = i;
        chk("t2_zorla_ver", obs_yv, 1);
        chk("t2_zorla_tahmin", obs_tv, 0);
      end
    end
    chk("t2_zorla_an", stall_idx, L + 1);
    chk("t2_zorla_tek", n_stall, 1);

    // Five back-to-back resolutions against a full queue.
    sifirla();
    tahmin_ps_gecerli_i = 1'b1;
    n_sent = 0;
    acc5   = -1;
    for (int i = 0; i < 30; i++) begin
      if (!yurut_ps_gecerli_i && n_sent < 5) sun(32'h300 + n_sent, n_sent[0], 1'b0);
      adim();
      if (i == 4) chk("t3_dolu", obs_hazir, 0);
      if (kabul) begin
        if (n_sent == 4) acc5 = i;
        n_sent++;
        yurut_ps_gecerli_i = 1'b0;
      end
    end
    chk("t3_besinci", acc5, L + 2);
    tahmin_ps_gecerli_i = 1'b0;
    for (int i = 0; i < 6; i++) adim();

    // Alternating lookup/idle: in-order issue on idle cycles, never forced.
    sifirla();
    tahmin_ps_gecerli_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sun(32'h10 * (k + 1), 1'b0, 1'b0);
      adim();
      yurut_ps_gecerli_i = 1'b0;
    end
    issued.delete();
    n_stall = 0;
    for (int j = 0; j < 8; j++) begin
      tahmin_ps_gecerli_i = j[0];
      adim();
      if (obs_yv) issued.push_back(obs_ps);
      if (obs_stall) n_stall++;
    end
    chk("t4_adet", issued.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t4_sira", (k < issued.size()) ? issued[k] : 32'hx, 32'h10 * (k + 1));
    chk("t4_zorla_yok", n_stall, 0);

    // Reset with three entries queued: nothing survives the release.
    sifirla();
    tahmin_ps_gecerli_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sun(32'h500 + k, 1'b1, 1'b0);
      adim();
      yurut_ps_gecerli_i = 1'b0;
    end
    tahmin_ps_gecerli_i = 1'b0;
    sifirla();
    n_ver = 0;
    for (int i = 0; i < 5; i++) begin
      adim();
      if (obs_yv) n_ver++;
    end
    chk("t5_ver_yok", n_ver, 0);

`ifdef ONGORU_SAYAC_EN
    sifirla();
    for (int k = 0; k < 3; k++) begin
      sun(32'h600 + k, (k != 1), 1'b0);
      adim();
      yurut_ps_gecerli_i = 1'b0;
    end
    for (int i = 0; i < 3; i++) adim();
    chk("t6_toplam", toplam_guncelleme_o, 3);
    chk("t6_yanlis", yanlis_guncelleme_o, 2);
`endif

    // Randomized traffic with a held-until-accepted producer.
    sifirla();
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) pct = $urandom_range(0, 95);
      tahmin_ps_gecerli_i = ($urandom_range(0, 99) < pct);
      tahmin_ps_i         = $urandom;
      if (!yurut_ps_gecerli_i && $urandom_range(0, 1) == 1)
        sun($urandom, $urandom_range(0, 1), $urandom_range(0, 1));
      if (i % 997 == 500) sifirla();
      adim();
      if (kabul) yurut_ps_gecerli_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ongoru_guncelleme_hakemi.md
# ongoru_guncelleme_hakemi

Arbiter and scheduler for the shared gshare predictor port. Fetch-stage prediction lookups and execute-stage resolution updates compete for the predictor, and the predictor drops an update whenever a lookup arrives in the same cycle. This block prevents that loss: it queues resolutions in a small FIFO, issues them only in cycles with no lookup, and briefly stalls fetch if an update waits too long. It sits between fetch/execute and the predictor.

## Interface
Parameters:
- FIFO_DERINLIK, 4, update queue depth; power of two, minimum 2.
- BEKLEME_SINIRI, 8, number of consecutive blocked cycles tolerated before an update is forced; minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- tahmin_ps_gecerli_i  in  1  fetch lookup request
- tahmin_ps_i  in  32  fetch PC
- yurut_ps_gecerli_i  in  1  execute resolution valid
- yurut_ps_i  in  32  resolved branch PC
- yanlis_tahmin_i  in  1  mispredicted
- yurut_atladi_i  in  1  branch taken
- yurut_hazir_o  out  1  queue can accept a resolution
- getir_durdur_o  out  1  fetch stall (forced-update cycle)
- ts_tahmin_gecerli_o  out  1  lookup valid toward predictor
- ts_tahmin_ps_o  out  32  lookup PC toward predictor
- ts_yurut_gecerli_o  out  1  update valid toward predictor
- ts_yurut_ps_o  out  32  update PC
- ts_yanlis_tahmin_o  out  1  update mispredict flag
- ts_yurut_atladi_o  out  1  update taken flag

## Operation
- Entry: {ps[31:0], yanlis, atladi}, 34 bits. A push occurs when yurut_ps_gecerli_i & yurut_hazir_o. A resolution presented while yurut_hazir_o=0 is the producer's responsibility to hold.
- yurut_hazir_o = (sayi != FIFO_DERINLIK). It is computed from the registered count, so a same-cycle pop does not free space for a same-cycle push.
- Lookup passthrough: ts_tahmin_gecerli_o = tahmin_ps_gecerli_i & ~getir_durdur_o. ts_tahmin_ps_o = tahmin_ps_i.
- Issue/pop: ts_yurut_gecerli_o = (sayi!=0) & (~tahmin_ps_gecerli_i | durum==ZORLA). Head fields drive ts_yurut_* directly; the head is popped in the same cycle.
- ts_yurut_gecerli_o and ts_tahmin_gecerli_o are never both 1.
- Entries are issued in FIFO order. They are never dropped and never reordered.
- bekleme_sayaci counts cycles with sayi!=0 and no issue. It clears on any issue or when the queue empties, and saturates at BEKLEME_SINIRI-1.
- States:
  - BOSTA: queue empty.
  - BEKLE: queue non-empty, normal issue.
  - ZORLA: forced-issue cycle.
- Transitions:
  - BOSTA→BEKLE on push.
  - BEKLE→ZORLA when bekleme_sayaci==BEKLEME_SINIRI-1 and the current cycle is blocked.
  - BEKLE→BOSTA when a pop empties the queue and there is no push.
  - ZORLA always lasts one cycle: →BOSTA if the queue is now empty, else →BEKLE.
- getir_durdur_o = (durum==ZORLA), a registered decode.
- Pointers wrap modulo FIFO_DERINLIK. sayi is $clog2(FIFO_DERINLIK)+1 bits wide.

## Timing
- Reset (async assert, sync release): queue empty, pointers 0, sayi 0, durum BOSTA, bekleme_sayaci 0, getir_durdur_o 0. With the queue empty all ts_yurut_* outputs read 0, and yurut_hazir_o=1.
- Minimum latency from accepted resolution to ts_yurut_gecerli_o is 1 cycle.
- Worst-case wait for the head entry is BEKLEME_SINIRI cycles plus one forced cycle.
- Simultaneous push and pop with 0<sayi<FIFO_DERINLIK: sayi is unchanged.
- Push into an empty queue during a lookup cycle: the entry is not issued that cycle. It enters BEKLE and the counter starts on the next cycle.
- Reset asserted mid-operation clears all queued updates immediately. Losing predictor accuracy here is acceptable.

## Configuration
- ONGORU_SAYAC_EN defined: adds two 32-bit wrapping outputs.
  - toplam_guncelleme_o counts issued updates.
  - yanlis_guncelleme_o counts issued updates with yanlis=1.
  - Both reset to 0.
- ONGORU_SAYAC_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - durum encodings BOSTA=2'd0, BEKLE=2'd1, ZORLA=2'd2.
  - the guncelleme_girdisi_t entry struct.
  - the PS_GENISLIK=32 constant.
- One sub-module, ongoru_guncelleme_fifo: a synchronous FIFO with registered count, hazir, and head outputs. The FSM and passthrough logic stay in the top.

## Test plan
- Reset, then one resolution {ps=0x100, yanlis=1, atladi=1} with no lookups → on the next cycle ts_yurut_gecerli_o=1 with ps=0x100, and the queue is empty afterwards.
- Lookup held high continuously while a single entry is queued → getir_durdur_o=1 for exactly one cycle, 8 cycles after entry, and the update issues in that cycle with ts_tahmin_gecerli_o=0.
- Five back-to-back resolutions with lookups active (depth 4) → yurut_hazir_o falls after the 4th push; the 5th is held and accepted after the first pop.
- Alternating lookup/idle cycles with 4 queued entries (PCs 0x10, 0x20, 0x30, 0x40) → issued in order on the idle cycles, and no ZORLA occurs.
- rst_ni pulled low with 3 entries queued → all outputs return to reset values asynchronously, and no update issues after release.
- With ONGORU_SAYAC_EN defined, issue 3 updates of which 2 have yanlis=1 → toplam_guncelleme_o=3 and yanlis_guncelleme_o=2.
